// File: rtl/keyboard_ctrl_if.sv
// CPU-side register bus of the keyboard controller: select, read/write strobes,
// write data, registered read data, ready pulse and level interrupt.
interface keyboard_ctrl_if;
    logic        sel;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] out;
    logic        irq;
    logic        rdy;

    modport master (
        output sel, rd_en, wr_en, wr_data,
        input  out, irq, rdy
    );

    modport slave (
        input  sel, rd_en, wr_en, wr_data,
        output out, irq, rdy
    );
endinterface

// File: rtl/keyboard_ctrl.sv
// Keyboard controller: edge-detects keystroke strobes, queues 7-bit codes in a
// FIFO and exposes DATA and STATUS/CTRL registers with a one-cycle read.
module keyboard_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         key_in,
    keyboard_ctrl_if.slave     bus
);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LAST_C  = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        logic [AW:0] n;
        if (p == LAST_C) begin
            n = {(AW + 1){1'b0}};
        end else begin
            n = p + ONE_C;
        end
        return n;
    endfunction

    logic [6:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r, rd_ptr_r, count_r;
    logic        prev_r, ovf_r, irq_en_r;
    logic [15:0] out_r;
    logic        rdy_r, irq_r;

    logic        push_s, pop_s, push_ok_s, flush_s, ctrl_wr_s;
    logic        full_s, empty_s, ovf_set_s;
    logic        rd_data_s, rd_stat_s;
    logic [4:0]  cnt5_s;
    logic [15:0] status_s;

    // Decode of strobes, FIFO conditions and the status word
    always_comb begin
        full_s    = (count_r == DEPTH_C);
        empty_s   = (count_r == {(AW + 1){1'b0}});
        push_s    = key_in[7] & ~prev_r;
        rd_data_s = bus.rd_en & ~bus.sel;
        rd_stat_s = bus.rd_en & bus.sel;
        // A read in the same cycle masks any write
        ctrl_wr_s = bus.wr_en & bus.sel & ~bus.rd_en;
        flush_s   = ctrl_wr_s & bus.wr_data[0];
        pop_s     = rd_data_s & ~empty_s;
        push_ok_s = push_s & (~full_s | pop_s) & ~flush_s;
        ovf_set_s = push_s & full_s & ~pop_s;
        cnt5_s    = 5'(count_r);
        status_s  = {3'b000, cnt5_s, 4'b0000, irq_en_r, ovf_r, full_s, ~empty_s};
    end

    // FIFO storage; contents need no reset since pointers guard them
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= key_in[6:0];
        end else begin
            mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
        end
    end

    // Pointers, occupancy and strobe history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
            count_r  <= {(AW + 1){1'b0}};
            prev_r   <= 1'b0;
        end else begin
            prev_r <= key_in[7];
            if (flush_s) begin
                wr_ptr_r <= {(AW + 1){1'b0}};
                rd_ptr_r <= {(AW + 1){1'b0}};
                count_r  <= {(AW + 1){1'b0}};
            end else begin
                if (push_ok_s) begin
                    wr_ptr_r <= ptr_inc(wr_ptr_r);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
                case ({push_ok_s, pop_s})
                    2'b10:   count_r <= count_r + ONE_C;
                    2'b01:   count_r <= count_r - ONE_C;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Control bits: sticky overflow (set beats clear) and interrupt enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r    <= 1'b0;
            irq_en_r <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                irq_en_r <= bus.wr_data[3];
            end else begin
                irq_en_r <= irq_en_r;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ctrl_wr_s && bus.wr_data[2]) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Registered bus outputs: read data, ready pulse and interrupt level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= 16'h0000;
            rdy_r <= 1'b0;
            irq_r <= 1'b0;
        end else begin
            rdy_r <= bus.rd_en;
            irq_r <= irq_en_r & ~empty_s;
            if (rd_data_s) begin
                out_r <= empty_s ? 16'h0000 : {9'b0_0000_0000, mem_r[rd_ptr_r[AW-1:0]]};
            end else if (rd_stat_s) begin
                out_r <= status_s;
            end else begin
                out_r <= out_r;
            end
        end
    end

    assign bus.out = out_r;
    assign bus.rdy = rdy_r;
    assign bus.irq = irq_r;
endmodule

// File: tb/tb_keyboard_ctrl.sv
// Scoreboard bench for keyboard_ctrl: a queue-based model predicts every read
// result and the interrupt level; a monitor checks reads when rdy pulses.
module tb_keyboard_ctrl;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key_in = 8'h00;
    keyboard_ctrl_if bus ();

    keyboard_ctrl #(.DEPTH(DEPTH), .AW(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [6:0]  q [$];
    logic [15:0] sb [$];
    logic        m_prev = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_irq_en = 1'b0;
    logic        exp_irq = 1'b0;

    function automatic logic [15:0] model_status();
        logic [4:0] n;
        n = 5'(q.size());
        return {3'b000, n, 4'b0000, m_irq_en, m_ovf, (q.size() == DEPTH), (q.size() != 0)};
    endfunction

    // Monitor: each rdy pulse pairs with the oldest predicted read result
    always @(negedge clk) begin
        if (rst_n && bus.rdy) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rdy_unexpected: rdy=1 out=%h, no read pending", bus.out);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (bus.out !== e) begin
                    failures++;
                    $display("FAIL read_data: got %h expected %h at %0t", bus.out, e, $time);
                end
            end
        end
    end

    task automatic step(input logic [7:0] key, input logic rd, input logic s,
                        input logic wr, input logic [15:0] wd);
        logic push, full, popped, flush, ovf_set;
        int   n;
        @(negedge clk);
        checks++;
        if (bus.irq !== exp_irq) begin
            failures++;
            $display("FAIL irq: got %b expected %b at %0t", bus.irq, exp_irq, $time);
        end
        exp_irq = m_irq_en && (q.size() != 0);
        key_in = key; bus.rd_en = rd; bus.sel = s; bus.wr_en = wr; bus.wr_data = wd;

        push = key[7] & ~m_prev;
        m_prev = key[7];
        n = q.size();
        full = (n == DEPTH);
        popped = 1'b0;
        if (rd) begin
            if (s) sb.push_back(model_status());
            else if (n > 0) sb.push_back({9'b0_0000_0000, q[0]});
            else sb.push_back(16'h0000);
        end
        flush = wr && s && !rd && wd[0];
        if (rd && !s && n > 0) begin
            void'(q.pop_front());
            popped = 1'b1;
        end
        if (flush) q.delete();
        else if (push && (!full || popped)) q.push_back(key[6:0]);
        ovf_set = push && full && !popped;
        if (wr && s && !rd) begin
            m_irq_en = wd[3];
            if (wd[2]) m_ovf = 1'b0;
        end
        if (ovf_set) m_ovf = 1'b1;
    endtask

    task automatic idle();            step(8'h00, 1'b0, 1'b0, 1'b0, 16'h0000); endtask
    task automatic rd_data();         step(8'h00, 1'b1, 1'b0, 1'b0, 16'h0000); endtask
    task automatic rd_stat();         step(8'h00, 1'b1, 1'b1, 1'b0, 16'h0000); endtask
    task automatic wr_ctrl(input logic [15:0] d); step(8'h00, 1'b0, 1'b1, 1'b1, d); endtask
    task automatic push_key(input logic [6:0] c);
        step({1'b1, c}, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle();
    endtask

    task automatic check_zero(input string name, input logic [15:0] v);
        checks++;
        if (v !== 16'h0000) begin
            failures++;
            $display("FAIL %s: got %h expected 0000", name, v);
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero("rst_out", bus.out);
        check_zero("rst_irq", {15'h0000, bus.irq});
        check_zero("rst_rdy", {15'h0000, bus.rdy});
        q.delete(); sb.delete();
        m_prev = 1'b0; m_ovf = 1'b0; m_irq_en = 1'b0; exp_irq = 1'b0;
        key_in = 8'h00; bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  k;
        logic        r, s, w, kb;
        logic [15:0] d;
        bus.sel = 1'b0; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.wr_data = 16'h0000;
        repeat (3) @(negedge clk);
        check_zero("reset_out", bus.out);
        rst_n = 1'b1;

        rd_stat(); push_key(7'h41); rd_stat(); rd_data(); rd_stat(); idle();

        repeat (5) step(8'hC2, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(); rd_stat(); rd_data(); rd_data(); idle();

        for (int i = 1; i <= 9; i++) push_key(7'(i));
        rd_stat();
        repeat (8) rd_data();
        wr_ctrl(16'h0004); rd_stat(); idle();

        for (int i = 0; i < 8; i++) push_key(7'(8'h10 + i));
        step(8'hA0, 1'b1, 1'b0, 1'b0, 16'h0000);
        idle(); rd_stat();
        repeat (8) rd_data();
        idle();

        wr_ctrl(16'h0008); push_key(7'h30); idle(); idle();
        rd_data(); idle(); idle();
        push_key(7'h31); push_key(7'h32); push_key(7'h33);
        wr_ctrl(16'h0001); idle(); idle(); rd_stat(); idle();

        for (int i = 0; i < 4; i++) push_key(7'(8'h50 + i));
        rd_stat();
        async_reset();
        rd_stat(); idle(); idle();

        kb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) kb = ~kb;
            k = {kb, 7'($urandom)};
            r = ($urandom_range(0, 9) < 3);
            s = 1'($urandom);
            w = ($urandom_range(0, 9) < 2);
            d = 16'($urandom);
            if (d[0] && $urandom_range(0, 3) != 0) d[0] = 1'b0;
            if (w && s && !r && d[0] && q.size() == DEPTH && kb && !m_prev) d[0] = 1'b0;
            step(k, r, s, w, d);
        end
        idle(); idle(); idle();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL pending_reads: %0d reads never answered, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keyboard_ctrl.md
Name: keyboard_ctrl

Overview:
Memory-mapped keyboard controller between the raw keystroke bus and the CPU I/O bus. It edge-detects keystroke strobes and queues 7-bit key codes in a FIFO. It exposes data and status/control registers with a one-cycle registered read, and raises a level interrupt while keys are pending and interrupts are enabled.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..16
AW, 3, log2(DEPTH); pointer width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
key_in  in  8  bit7 = key strobe (level, may be held several cycles), bits[6:0] = key code
sel  in  1  register select: 0 = DATA, 1 = STATUS/CTRL
rd_en  in  1  read strobe, one cycle per access
wr_en  in  1  write strobe, one cycle per access
wr_data  in  16  write data (STATUS/CTRL only)
out  out  16  registered read data
irq  out  1  interrupt request, level
rdy  out  1  pulses high for one cycle, the cycle after an accepted rd_en

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pointers and count 0, overflow flag 0, irq_en 0, strobe history 0, out = 0, rdy = 0, irq = 0. Reset mid-operation discards all queued keys.
- Strobe detect: register key_in[7] as prev. Push request = key_in[7] & ~prev. Exactly one push per rising edge however long the strobe is held. The code is key_in[6:0] sampled in the edge cycle.
- FIFO: write pointer, read pointer and count are AW+1 bits. Both pointers wrap modulo DEPTH.
- full = (count == DEPTH); empty = (count == 0).
- DATA read (rd_en & ~sel):
  - If not empty: out <= {9'b0, head code} next cycle, pop the entry.
  - If empty: out <= 16'h0000, no pop.
  - Latency is 1 cycle. out holds its value until the next read.
- STATUS read (rd_en & sel): out <= {count[4:0] in bits[12:8], 4'b0 in bits[7:4], irq_en in bit3, overflow in bit2, full in bit1, ~empty in bit0}. All other bits are 0. The status read does not pop.
- rdy: rdy <= rd_en every cycle.
- CTRL write (wr_en & sel):
  - bit3 -> irq_en.
  - bit2 = 1 clears overflow (write-one-to-clear).
  - bit0 = 1 flushes the FIFO (pointers and count to 0).
  - Other bits are ignored.
- wr_en with sel = 0 is ignored.
- Simultaneous rd_en & wr_en: the read is serviced and the write is ignored.
- Push while full:
  - If a DATA pop occurs in the same cycle, the push is accepted and count stays DEPTH.
  - Otherwise the key is dropped, overflow <= 1 (sticky), and FIFO contents are unchanged.
- Push and pop in the same cycle, not full, not empty: both occur and count is unchanged.
- Push while empty with a DATA read in the same cycle: the read returns 0 and the key is stored (count becomes 1). There is no bypass.
- Flush in the same cycle as a push: the flush wins and the key is discarded. The overflow flag is not affected by flush.
- irq = irq_en & ~empty, registered (updates the cycle after the state change).
- Overflow-clear and a new overflow in the same cycle: the set wins (overflow = 1).

Test Plan:
- Reset then STATUS read -> out = 16'h0000, irq = 0. Pulse key_in = 8'hC1 for 1 cycle, then STATUS read -> out = 16'h0101. DATA read -> out = 16'h0041, rdy one cycle later. Next STATUS read -> 16'h0000.
- Hold key_in = 8'hC2 high for 5 cycles, then release -> exactly one entry (STATUS = 16'h0101). Two DATA reads -> 16'h0042, then 16'h0000.
- Push codes 0x01..0x09 (9 edges, DEPTH = 8) -> STATUS = 16'h0807 (count 8, overflow, full, not-empty). Eight DATA reads return 0x01..0x08 in order, proving wrap is correct. Write CTRL 16'h0004 -> overflow cleared, STATUS = 16'h0000.
- Full FIFO, push edge coincident with a DATA read -> the read returns the oldest code, the new code is appended, overflow stays 0, count stays 8.
- Write CTRL 16'h0008, then push 0x30 -> irq rises one cycle after the push. DATA read -> irq falls one cycle after the pop. Write CTRL 16'h0001 with 3 keys queued -> count 0, irq 0.
- With 4 keys queued, assert rst_n low mid-cycle (asynchronously) -> out, irq and rdy go to 0 immediately. After release, STATUS = 16'h0000.
